// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-code output and a sticky
// checker that flags any count step whose Gray change is not exactly one bit.
module bin_to_gray_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  output logic [N-1:0] bin,
  output logic [N-1:0] gray,
  output logic         wrap,
  output logic         step_err
);

  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ALL1 = '1;

  logic [N-1:0] step_bin;
  logic [N-1:0] step_gray;
  logic [N-1:0] load_gray;
  logic         step_wrap;
  logic         step_bad;

  function automatic int popcount(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    step_bin  = up ? (bin + ONE) : (bin - ONE);
    step_gray = step_bin ^ (step_bin >> 1);
    load_gray = load_bin ^ (load_bin >> 1);
    step_wrap = up ? (bin == ALL1) : (bin == ZERO);
    // Checked against the registered gray, so a broken encoder is caught.
    step_bad  = (popcount(step_gray ^ gray) != 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin      <= '0;
      gray     <= '0;
      wrap     <= 1'b0;
      step_err <= 1'b0;
    end else if (load) begin
      bin  <= load_bin;
      gray <= load_gray;
      wrap <= 1'b0;
    end else if (en) begin
      bin  <= step_bin;
      gray <= step_gray;
      wrap <= step_wrap;
      if (step_bad) begin
        step_err <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Randomised and directed bench for bin_to_gray_counter; a reference model
// pushes expected outputs into a queue that a monitor drains each cycle.
module tb_bin_to_gray_counter;

  localparam int N    = 4;
  localparam int SIZE = 1 << N;
  localparam int EW   = 2 * N + 2;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] load_bin;
  logic [N-1:0] bin;
  logic [N-1:0] gray;
  logic         wrap;
  logic         step_err;

  logic [EW-1:0] exp_q[$];
  int checks;
  int failures;

  // reference model state
  int m_cnt;
  int m_wrap;
  int m_err;
  int gtab[SIZE];

  bin_to_gray_counter #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap),
    .step_err (step_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gray table built by reflection, independent of the xor-shift formula.
  task automatic build_gray_table();
    gtab[0] = 0;
    for (int k = 0; k < N; k++) begin
      int sz;
      sz = 1 << k;
      for (int i = 0; i < sz; i++) begin
        gtab[2 * sz - 1 - i] = gtab[i] + sz;
      end
    end
  endtask

  function automatic logic [N-1:0] gray_decode(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  task automatic drive(input logic r, input logic ld, input int lv,
                       input logic e, input logic u);
    int nxt;
    logic [N-1:0] eb;
    logic [N-1:0] eg;
    @(negedge clk);
    rst      = r;
    load     = ld;
    load_bin = N'(lv);
    en       = e;
    up       = u;
    if (r) begin
      m_cnt = 0; m_wrap = 0; m_err = 0;
    end else if (ld) begin
      m_cnt = lv; m_wrap = 0;
    end else if (e) begin
      nxt    = u ? m_cnt + 1 : m_cnt - 1;
      m_wrap = (nxt < 0 || nxt >= SIZE) ? 1 : 0;
      m_cnt  = (nxt + SIZE) % SIZE;
    end else begin
      m_wrap = 0;
    end
    eb = N'(m_cnt);
    eg = N'(gtab[m_cnt]);
    exp_q.push_back({eb, eg, m_wrap[0], m_err[0]});
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: the counter presents a new result every cycle after a stimulus
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bin", int'(bin), int'(e[EW-1 -: N]));
        check("gray", int'(gray), int'(e[N+1 -: N]));
        check("wrap", int'(wrap), int'(e[1]));
        check("step_err", int'(step_err), int'(e[0]));
        check("decode", int'(gray_decode(gray)), int'(e[EW-1 -: N]));
      end
    end
  end

  initial begin
    int r;
    int budget;
    checks = 0; failures = 0;
    m_cnt = 0; m_wrap = 0; m_err = 0;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    build_gray_table();

    // reset then a full lap upward
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < SIZE; i++) drive(0, 0, 0, 1, 1);

    // down through zero from reset
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    // load and resume
    drive(0, 1, 'b1010, 0, 0);
    drive(0, 0, 0, 1, 1);

    // hold and priority
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1);
    drive(0, 1, 'b0011, 1, 1);
    drive(1, 1, 'b0110, 1, 1);

    // reset mid-count at 0111 then resume
    drive(0, 1, 'b0101, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1);

    // every load value, back to back
    for (int v = 0; v < SIZE; v++) drive(0, 1, v, 0, 0);

    // back-to-back wraps in both directions
    drive(0, 1, SIZE - 1, 0, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);

    // random mix
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      drive(r < 3, (r >= 3 && r < 12), $urandom_range(0, SIZE - 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    drive(0, 0, 0, 0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_gray_counter.md
Name: bin_to_gray_counter

Overview:
Up/down binary counter with a registered Gray-code output. It is the encoding end of our Gray datapath and feeds the Gray-to-binary decoder, e.g. as an async-FIFO pointer source. Both binary and Gray values are registered and update on the same edge, so the Gray bus is glitch-free and changes one bit per count step. An on-chip step checker flags any count step where Gray changes more or less than one bit.

Parameters:
N, 4, counter width in bits for both binary and Gray outputs (N >= 2).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  count enable; one step per cycle while high.
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
load  input  1  synchronous load of load_bin.
load_bin  input  N  binary value to load.
bin  output  N  registered binary count.
gray  output  N  registered Gray code of bin: bin ^ (bin >> 1).
wrap  output  1  registered one-cycle pulse; counter wrapped on the previous step.
step_err  output  1  sticky flag; a count step produced a Gray change of Hamming distance != 1.

Behaviour:
- Reset: while rst=1 at a rising edge: bin=0, gray=0, wrap=0, step_err=0. rst overrides all other inputs. Reset mid-count returns to 0 on that edge with no wrap pulse.
- Priority per edge: rst > load > en > hold.
- Load (load=1):
  - bin <= load_bin; gray <= load_bin ^ (load_bin >> 1); wrap <= 0.
  - en and up are ignored that cycle.
  - The step checker does not evaluate load transitions.
- Count (en=1, load=0):
  - up=1: bin <= bin + 1, modulo 2^N.
  - up=0: bin <= bin - 1, modulo 2^N.
  - gray is computed from the next binary value and registered on the same edge as bin. Latency from the en edge to the visible change is 1 cycle for both outputs, with no skew between them.
- Hold (en=0, load=0): bin and gray are unchanged; wrap <= 0.
- wrap:
  - Asserts for exactly one cycle after a step that rolls over: up from 2^N-1 to 0, or down from 0 to 2^N-1.
  - Otherwise deasserts on every edge.
  - Consecutive wraps (e.g. N steps with small N) each produce their own pulse.
- step_err:
  - On each count step, popcount(gray_next ^ gray) must equal 1; if it does not, step_err <= 1.
  - Once set, it stays set until rst.
  - With correct RTL it never asserts. It exists for the verification/SVA hook and must be implemented on the real registered value.
- Arithmetic: all N-bit, unsigned, with natural modulo wrap; no saturation.
- Gray bit mapping: gray[N-1] = bin[N-1]; gray[i] = bin[i+1] ^ bin[i] for i < N-1.
- No combinational path from any input to any output; all outputs come directly from flops.

Test Plan:
1. Reset then count up: rst=1 for 2 cycles, then en=1, up=1 for 16 cycles (N=4) -> gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. wrap=1 only in the cycle after bin goes 1111->0000. step_err stays 0.
2. Count down through zero: from reset, en=1, up=0 for 1 cycle -> bin=1111, gray=1000, wrap=1 for one cycle. Next step gives bin=1110, gray=1001, wrap=0.
3. Load and resume: load=1, load_bin=1010 -> next cycle bin=1010, gray=1111, wrap=0, step_err=0 (load is exempt from the check). Then en=1, up=1 -> bin=1011, gray=1110.
4. Hold and priority:
   - en=0 for 5 cycles -> outputs unchanged.
   - load=1 and en=1 with load_bin=0011 -> bin=0011, gray=0010 (load wins).
   - rst=1 with load=1 -> bin=0, gray=0.
5. Reset mid-operation: counting up at bin=0111 with rst=1 for one cycle -> bin=0, gray=0, wrap=0, step_err=0. Counting resumes at 0001 the cycle after rst drops.
6. Exhaustive encode check: loop all 2^N load values -> gray == load_bin ^ (load_bin >> 1) one cycle after each load. Cross-check by feeding gray into the Gray-to-binary decoder -> decoded output equals bin.
